uart_rx_param: RTL and testbench

- Parametrised next-generation serial receiver.
- Oversamples `rxd` on the baud-generator enable and recovers each bit by majority vote.
- Supports configurable data width, parity and stop bits, with framing/parity error detection.
- Buffers received frames in a small show-ahead FIFO so the processor can read them late without losing characters.
- Sits between the baud rate generator / serial pin and the processor bus.

---
 rtl/uart_rx_param_if.sv | 24 ++
 rtl/uart_rx_param.sv | 196 +++++++++++++++++++
 tb/tb_uart_rx_param.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_param_if.sv
// Processor-side bus of the serial receiver: read strobe in, head-of-FIFO entry and status out.
// The receiver takes the slave modport; the reading agent takes the master modport.
interface uart_rx_param_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
);
  logic                          rec_enable;
  logic [DATA_BITS-1:0]          data;
  logic                          rda;
  logic                          parity_err;
  logic                          frame_err;
  logic                          overrun;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;

  modport master (
    output rec_enable,
    input  data, rda, parity_err, frame_err, overrun, fifo_count
  );

  modport slave (
    input  rec_enable,
    output data, rda, parity_err, frame_err, overrun, fifo_count
  );
endinterface

// File: rtl/uart_rx_param.sv
// Oversampling majority-vote serial receiver with a show-ahead frame FIFO.
// Frame lands in the FIFO on the final stop-bit decision cycle; a push into a full FIFO without a pop is dropped and flagged as overrun.
module uart_rx_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             r_enable,
  input  logic             rxd,
  uart_rx_param_if.slave   bus
);
  localparam int CW = $clog2(OVERSAMPLE + 1);
  localparam int IW = 4;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int NW = PW + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  localparam logic [IW-1:0] LAST_DATA = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

  typedef struct packed {
    logic [DATA_BITS-1:0] dat;
    logic                 perr;
    logic                 ferr;
  } entry_t;

  logic sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rxd;
      sync2_q <= sync1_q;
    end
  end

  logic [2:0]           state_q, state_d;
  logic [CW-1:0]        scnt_q, scnt_d, zcnt_q, zcnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 perr_q, perr_d, ferr_q, ferr_d;
  logic                 decide, bit_val, par_x, push;
  entry_t               new_e;

  // Decision cycle follows the pulse that brought the count to OVERSAMPLE.
  assign decide  = (state_q != S_IDLE) && (scnt_q == CW'(OVERSAMPLE));
  assign bit_val = !(zcnt_q > CW'(OVERSAMPLE / 2));
  assign par_x   = ^{shreg_q, bit_val};

  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    zcnt_d  = zcnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    push    = 1'b0;
    if (state_q == S_IDLE) begin
      if (r_enable && !sync2_q) begin
        scnt_d  = CW'(1);
        zcnt_d  = CW'(1);
        state_d = S_START;
      end
    end else if (decide) begin
      scnt_d = '0;
      zcnt_d = '0;
      case (state_q)
        S_START: begin
          if (!bit_val) begin
            state_d = S_DATA;
            idx_d   = '0;
            shreg_d = '0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_DATA: begin
          shreg_d = {bit_val, shreg_q[DATA_BITS-1:1]};
          if (idx_q == LAST_DATA) begin
            idx_d   = '0;
            state_d = (PARITY != 0) ? S_PAR : S_STOP;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
        S_PAR: begin
          perr_d  = (PARITY == 1) ? par_x : !par_x;
          state_d = S_STOP;
        end
        S_STOP: begin
          if (!bit_val) ferr_d = 1'b1;
          if (idx_q == LAST_STOP) begin
            push    = 1'b1;
            idx_d   = '0;
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (r_enable) begin
      scnt_d = scnt_q + CW'(1);
      zcnt_d = zcnt_q + CW'(!sync2_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      scnt_q  <= '0;
      zcnt_q  <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
      zcnt_q  <= zcnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  // The last stop bit's own verdict is folded in here, not in ferr_q.
  assign new_e = '{dat: shreg_q, perr: perr_q, ferr: ferr_q | !bit_val};

  entry_t          mem_q [FIFO_DEPTH];
  entry_t          head_q, head_d;
  logic [PW-1:0]   wr_q, rd_q, rd_d;
  logic [NW-1:0]   cnt_q, cnt_d;
  logic            overrun_q, overrun_d;
  logic            pop, full, push_acc;

  assign pop      = bus.rec_enable && (cnt_q != '0);
  assign full     = (cnt_q == NW'(FIFO_DEPTH));
  assign push_acc = push && (!full || pop);

  always_comb begin
    rd_d      = rd_q + PW'(pop);
    cnt_d     = cnt_q + NW'(push_acc) - NW'(pop);
    head_d    = head_q;
    overrun_d = overrun_q;
    // Head register holds its last value once the FIFO drains.
    if (cnt_d != '0) begin
      if (push_acc && (wr_q == rd_d)) head_d = new_e;
      else                            head_d = mem_q[rd_d];
    end
    if (pop)                   overrun_d = 1'b0;
    if (push && full && !pop)  overrun_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push_acc) mem_q[wr_q] <= new_e;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      head_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_q      <= wr_q + PW'(push_acc);
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
      head_q    <= head_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.data       = head_q.dat;
  assign bus.parity_err = head_q.perr;
  assign bus.frame_err  = head_q.ferr;
  assign bus.rda        = (cnt_q != '0);
  assign bus.overrun    = overrun_q;
  assign bus.fifo_count = cnt_q;
endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: default instance (no parity) and an even-parity instance.
module tb_uart_rx_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic r_enable = 1'b0;
  logic rxd0 = 1'b1;
  logic rxd1 = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  uart_rx_param_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) bus0 ();
  uart_rx_param_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) bus1 ();

  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut0 (
    .clk(clk), .rst(rst), .r_enable(r_enable), .rxd(rxd0), .bus(bus0)
  );

  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) dut1 (
    .clk(clk), .rst(rst), .r_enable(r_enable), .rxd(rxd1), .bus(bus1)
  );

  // One oversample: line settles through the synchroniser, then a one-clk r_enable pulse.
  task automatic samp(input int d, input logic v);
    if (d == 0) rxd0 = v; else rxd1 = v;
    r_enable = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 r_enable = 1'b1;
    @(posedge clk);
    #1 r_enable = 1'b0;
  endtask

  // Samples 1..nflip of the bit period carry the inverted level.
  task automatic send_bit(input int d, input logic v, input int nflip);
    for (int i = 0; i < 16; i++) samp(d, (i >= 1 && i <= nflip) ? ~v : v);
  endtask

  task automatic send_frame(input int d, input logic [7:0] b, input int nflip, input int flip0,
                            input logic par_en, input logic par, input logic stopv);
    send_bit(d, 1'b0, nflip);
    for (int i = 0; i < 8; i++) send_bit(d, b[i], (i == 0) ? flip0 : nflip);
    if (par_en) send_bit(d, par, nflip);
    send_bit(d, stopv, nflip);
  endtask

  task automatic pop(input int d);
    if (d == 0) bus0.rec_enable = 1'b1; else bus1.rec_enable = 1'b1;
    @(posedge clk);
    #1;
    bus0.rec_enable = 1'b0;
    bus1.rec_enable = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus0.rda !== 1'b0) begin bad++; $display("FAIL reset_rda got=%b want=0", bus0.rda); end
    total++; if (bus0.data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", bus0.data); end
    total++; if (bus0.fifo_count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", bus0.fifo_count); end
    total++; if (bus0.overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b want=0", bus0.overrun); end
    total++; if ({bus0.parity_err, bus0.frame_err} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b want=00", {bus0.parity_err, bus0.frame_err}); end
    total++; if (bus1.rda !== 1'b0) begin bad++; $display("FAIL reset_rda1 got=%b want=0", bus1.rda); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    send_frame(0, 8'h5A, 0, 0, 1'b0, 1'b0, 1'b1);
    total++; if (bus0.rda !== 1'b0) begin bad++; $display("FAIL basic_rda_early got=%b want=0", bus0.rda); end
    @(posedge clk); #1;
    total++; if (bus0.rda !== 1'b1) begin bad++; $display("FAIL basic_rda got=%b want=1", bus0.rda); end
    total++; if (bus0.data !== 8'h5A) begin bad++; $display("FAIL basic_data got=%h want=5a", bus0.data); end
    total++; if ({bus0.parity_err, bus0.frame_err} !== 2'b00) begin bad++; $display("FAIL basic_flags got=%b want=00", {bus0.parity_err, bus0.frame_err}); end
    total++; if (bus0.fifo_count !== 3'd1) begin bad++; $display("FAIL basic_count got=%0d want=1", bus0.fifo_count); end
    pop(0);
    total++; if (bus0.rda !== 1'b0) begin bad++; $display("FAIL basic_rda_after_pop got=%b want=0", bus0.rda); end
    total++; if (bus0.data !== 8'h5A) begin bad++; $display("FAIL basic_data_hold got=%h want=5a", bus0.data); end
    pop(0);
    total++; if (bus0.fifo_count !== 3'd0) begin bad++; $display("FAIL basic_empty_pop got=%0d want=0", bus0.fifo_count); end
  endtask

  task automatic test_glitch();
    for (int i = 0; i < 6; i++) samp(0, 1'b0);
    for (int i = 0; i < 14; i++) samp(0, 1'b1);
    total++; if (bus0.rda !== 1'b0) begin bad++; $display("FAIL glitch_rda got=%b want=0", bus0.rda); end
    total++; if (bus0.fifo_count !== 3'd0) begin bad++; $display("FAIL glitch_count got=%0d want=0", bus0.fifo_count); end
    send_frame(0, 8'h00, 0, 0, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    total++; if (bus0.rda !== 1'b1) begin bad++; $display("FAIL glitch_next_rda got=%b want=1", bus0.rda); end
    total++; if (bus0.data !== 8'h00) begin bad++; $display("FAIL glitch_next_data got=%h want=00", bus0.data); end
    pop(0);
  endtask

  task automatic test_noise();
    send_frame(0, 8'hA5, 7, 7, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    total++; if (bus0.data !== 8'hA5) begin bad++; $display("FAIL noise_data got=%h want=a5", bus0.data); end
    total++; if (bus0.frame_err !== 1'b0) begin bad++; $display("FAIL noise_ferr got=%b want=0", bus0.frame_err); end
    pop(0);
    // Bit 0 driven low but with only 8 of 16 samples low: a tie decides as 1.
    send_frame(0, 8'hA4, 0, 8, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    total++; if (bus0.data !== 8'hA5) begin bad++; $display("FAIL noise_tie got=%h want=a5", bus0.data); end
    pop(0);
  endtask

  task automatic test_parity();
    send_frame(1, 8'h07, 0, 0, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #1;
    total++; if (bus1.parity_err !== 1'b1) begin bad++; $display("FAIL par_bad got=%b want=1", bus1.parity_err); end
    total++; if (bus1.data !== 8'h07) begin bad++; $display("FAIL par_data got=%h want=07", bus1.data); end
    pop(1);
    send_frame(1, 8'h07, 0, 0, 1'b1, 1'b1, 1'b1);
    @(posedge clk); #1;
    total++; if (bus1.parity_err !== 1'b0) begin bad++; $display("FAIL par_good got=%b want=0", bus1.parity_err); end
    total++; if (bus1.frame_err !== 1'b0) begin bad++; $display("FAIL par_good_ferr got=%b want=0", bus1.frame_err); end
    pop(1);
    send_frame(1, 8'h3C, 0, 0, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    total++; if (bus1.rda !== 1'b1) begin bad++; $display("FAIL stop0_rda got=%b want=1", bus1.rda); end
    total++; if (bus1.frame_err !== 1'b1) begin bad++; $display("FAIL stop0_ferr got=%b want=1", bus1.frame_err); end
    total++; if (bus1.parity_err !== 1'b0) begin bad++; $display("FAIL stop0_perr got=%b want=0", bus1.parity_err); end
    total++; if (bus1.data !== 8'h3C) begin bad++; $display("FAIL stop0_data got=%h want=3c", bus1.data); end
    pop(1);
    for (int i = 0; i < 4; i++) samp(1, 1'b1);
    total++; if (bus1.rda !== 1'b0) begin bad++; $display("FAIL stop0_idle got=%b want=0", bus1.rda); end
  endtask

  task automatic fill(input int n);
    logic [7:0] v;
    for (int i = 0; i < n; i++) begin
      v = 8'h11 * (i + 1);
      send_frame(0, v, 0, 0, 1'b0, 1'b0, 1'b1);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_overrun();
    logic [7:0] exp_v;
    fill(4);
    total++; if (bus0.fifo_count !== 3'd4) begin bad++; $display("FAIL ovr_count4 got=%0d want=4", bus0.fifo_count); end
    total++; if (bus0.overrun !== 1'b0) begin bad++; $display("FAIL ovr_early got=%b want=0", bus0.overrun); end
    send_frame(0, 8'h55, 0, 0, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    total++; if (bus0.fifo_count !== 3'd4) begin bad++; $display("FAIL ovr_count got=%0d want=4", bus0.fifo_count); end
    total++; if (bus0.overrun !== 1'b1) begin bad++; $display("FAIL ovr_flag got=%b want=1", bus0.overrun); end
    for (int i = 0; i < 4; i++) begin
      exp_v = 8'h11 * (i + 1);
      total++; if (bus0.data !== exp_v) begin bad++; $display("FAIL ovr_read%0d got=%h want=%h", i, bus0.data, exp_v); end
      pop(0);
      if (i == 0) begin
        total++; if (bus0.overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%b want=0", bus0.overrun); end
      end
    end
    total++; if (bus0.rda !== 1'b0) begin bad++; $display("FAIL ovr_drained got=%b want=0", bus0.rda); end
  endtask

  task automatic test_full_pop();
    logic [7:0] exp_v;
    fill(4);
    send_frame(0, 8'h55, 0, 0, 1'b0, 1'b0, 1'b1);
    pop(0);
    total++; if (bus0.fifo_count !== 3'd4) begin bad++; $display("FAIL fullpop_count got=%0d want=4", bus0.fifo_count); end
    total++; if (bus0.overrun !== 1'b0) begin bad++; $display("FAIL fullpop_overrun got=%b want=0", bus0.overrun); end
    for (int i = 0; i < 4; i++) begin
      exp_v = 8'h11 * (i + 2);
      total++; if (bus0.data !== exp_v) begin bad++; $display("FAIL fullpop_read%0d got=%h want=%h", i, bus0.data, exp_v); end
      pop(0);
    end
    total++; if (bus0.rda !== 1'b0) begin bad++; $display("FAIL fullpop_drained got=%b want=0", bus0.rda); end
  endtask

  task automatic test_reset_mid();
    fill(5);
    total++; if (bus0.overrun !== 1'b1) begin bad++; $display("FAIL rstmid_pre_ovr got=%b want=1", bus0.overrun); end
    send_bit(0, 1'b0, 0);
    send_bit(0, 1'b1, 0);
    send_bit(0, 1'b0, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    total++; if (bus0.rda !== 1'b0) begin bad++; $display("FAIL rstmid_rda got=%b want=0", bus0.rda); end
    total++; if (bus0.data !== 8'h00) begin bad++; $display("FAIL rstmid_data got=%h want=00", bus0.data); end
    total++; if (bus0.fifo_count !== 3'd0) begin bad++; $display("FAIL rstmid_count got=%0d want=0", bus0.fifo_count); end
    total++; if (bus0.overrun !== 1'b0) begin bad++; $display("FAIL rstmid_ovr got=%b want=0", bus0.overrun); end
    total++; if ({bus0.parity_err, bus0.frame_err} !== 2'b00) begin bad++; $display("FAIL rstmid_flags got=%b want=00", {bus0.parity_err, bus0.frame_err}); end
    rxd0 = 1'b1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) samp(0, 1'b1);
    send_frame(0, 8'hC3, 0, 0, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    total++; if (bus0.data !== 8'hC3) begin bad++; $display("FAIL rstmid_next_data got=%h want=c3", bus0.data); end
    total++; if (bus0.fifo_count !== 3'd1) begin bad++; $display("FAIL rstmid_next_count got=%0d want=1", bus0.fifo_count); end
    pop(0);
  endtask

  initial begin
    bus0.rec_enable = 1'b0;
    bus1.rec_enable = 1'b0;
    test_reset();
    test_basic();
    test_glitch();
    test_noise();
    test_parity();
    test_overrun();
    test_full_pop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule
